// File: rtl/ctrl_reg_pkg.sv
// Shared definitions for the control-register bridge: FSM state encoding,
// error read-back word, default external base address and the address-class
// decoder used to route a request to control, status, external or nowhere.
package ctrl_reg_pkg;

  // FSM encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DECODE   = 2'd1;
  localparam logic [1:0] ST_EXT_WAIT = 2'd2;
  localparam logic [1:0] ST_ACK_HOLD = 2'd3;

  // Read-back word for unmapped accesses and external timeouts
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  localparam logic [15:0] DEFAULT_EXT_BASE = 16'h0100;

  typedef enum logic [1:0] {
    LOCAL_CTRL = 2'd0,
    LOCAL_STAT = 2'd1,
    EXT        = 2'd2,
    UNMAPPED   = 2'd3
  } addr_class_t;

  // Local ranges take priority should the external base ever overlap them.
  function automatic addr_class_t addr_class(input logic [15:0] addr,
                                             input int nctrl,
                                             input int nstat,
                                             input logic [15:0] ext_base);
    if (int'(addr) < nctrl)              return LOCAL_CTRL;
    else if (int'(addr) < nctrl + nstat) return LOCAL_STAT;
    else if (addr >= ext_base)           return EXT;
    else                                 return UNMAPPED;
  endfunction

endpackage

// File: rtl/ext_bus_timer.sv
// External-bus wait timer: 8-bit counter, cleared on request launch, counts
// while enabled and parks at LIMIT, raising expired (registered count, 0 lat).
// Ports: clk/rst, clr (synchronous clear), en (count enable), expired.
module ext_bus_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  assign expired = (count == 8'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en && !expired) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/control_reg_bridge.sv
// Control-link register bridge: serves local RW control / RO status registers
// and forwards the upper address range to an external bus with a timeout.
// Latency: ack two edges after strobe is sampled; ack held until strobe drops.
// Ports: byte_clk/reset; strobe/address/requestIsWrite/wdata -> ack/rdata
// (4-phase link side); ctrlOut/statusIn register bank; ext* external bus;
// errCount counts unmapped accesses and external timeouts (saturating).
module control_reg_bridge
  import ctrl_reg_pkg::*;
#(
  parameter int          NCTRL    = 8,
  parameter int          NSTAT    = 8,
  parameter logic [15:0] EXT_BASE = DEFAULT_EXT_BASE,
  parameter int          TIMEOUT  = 255
) (
  input  logic                  byte_clk,
  input  logic                  reset,
  input  logic                  strobe,
  input  logic [15:0]           address,
  input  logic                  requestIsWrite,
  input  logic [31:0]           wdata,
  output logic                  ack,
  output logic [31:0]           rdata,
  output logic [32*NCTRL-1:0]   ctrlOut,
  input  logic [32*NSTAT-1:0]   statusIn,
  output logic                  extStrobe,
  output logic                  extWrite,
  output logic [15:0]           extAddress,
  output logic [31:0]           extWdata,
  input  logic                  extAck,
  input  logic [31:0]           extRdata,
  output logic [15:0]           errCount
);

  // Strobe is registered before the FSM sees it; this is the sampling point
  // that all handshake timing is measured from.
  logic        strobe_q;
  logic [1:0]  state;
  logic [15:0] addr_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic [31:0] ctrl_q [NCTRL];

  addr_class_t acls;
  logic [31:0] ctrl_rd;
  logic [31:0] stat_rd;
  logic        tmr_expired;

  assign acls = addr_class(addr_q, NCTRL, NSTAT, EXT_BASE);

  for (genvar g = 0; g < NCTRL; g++) begin : g_ctrl_out
    assign ctrlOut[32*g +: 32] = ctrl_q[g];
  end

  always_comb begin
    ctrl_rd = '0;
    for (int i = 0; i < NCTRL; i++) begin
      if (addr_q == 16'(i)) ctrl_rd = ctrl_q[i];
    end
  end

  always_comb begin
    stat_rd = '0;
    for (int i = 0; i < NSTAT; i++) begin
      if (addr_q == 16'(NCTRL + i)) stat_rd = statusIn[32*i +: 32];
    end
  end

  ext_bus_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk     (byte_clk),
    .rst     (reset),
    .clr     (state == ST_DECODE),
    .en      (state == ST_EXT_WAIT),
    .expired (tmr_expired)
  );

  always_ff @(posedge byte_clk or posedge reset) begin
    if (reset) begin
      strobe_q   <= 1'b0;
      state      <= ST_IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      ack        <= 1'b0;
      rdata      <= '0;
      extStrobe  <= 1'b0;
      extWrite   <= 1'b0;
      extAddress <= '0;
      extWdata   <= '0;
      errCount   <= '0;
      for (int i = 0; i < NCTRL; i++) ctrl_q[i] <= '0;
    end else begin
      strobe_q <= strobe;
      case (state)
        ST_IDLE: begin
          if (strobe_q) begin
            addr_q  <= address;
            wr_q    <= requestIsWrite;
            wdata_q <= wdata;
            state   <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          // A local write commits here even if the request is being aborted.
          if (acls == LOCAL_CTRL && wr_q) begin
            for (int i = 0; i < NCTRL; i++) begin
              if (addr_q == 16'(i)) ctrl_q[i] <= wdata_q;
            end
          end
          if (!strobe_q) begin
            state <= ST_IDLE;
          end else begin
            case (acls)
              LOCAL_CTRL: begin
                rdata <= wr_q ? wdata_q : ctrl_rd;
                ack   <= 1'b1;
                state <= ST_ACK_HOLD;
              end
              LOCAL_STAT: begin
                rdata <= stat_rd;
                ack   <= 1'b1;
                state <= ST_ACK_HOLD;
              end
              EXT: begin
                extStrobe  <= 1'b1;
                extWrite   <= wr_q;
                extAddress <= addr_q;
                extWdata   <= wdata_q;
                state      <= ST_EXT_WAIT;
              end
              default: begin
                rdata <= ERR_WORD;
                if (errCount != 16'hFFFF) errCount <= errCount + 16'd1;
                ack   <= 1'b1;
                state <= ST_ACK_HOLD;
              end
            endcase
          end
        end

        ST_EXT_WAIT: begin
          if (!strobe_q) begin
            extStrobe <= 1'b0;
            state     <= ST_IDLE;
          end else if (extAck) begin
            // extAck beats a simultaneous timeout.
            extStrobe <= 1'b0;
            rdata     <= wr_q ? wdata_q : extRdata;
            ack       <= 1'b1;
            state     <= ST_ACK_HOLD;
          end else if (tmr_expired) begin
            extStrobe <= 1'b0;
            rdata     <= ERR_WORD;
            if (errCount != 16'hFFFF) errCount <= errCount + 16'd1;
            ack       <= 1'b1;
            state     <= ST_ACK_HOLD;
          end
        end

        default: begin  // ST_ACK_HOLD
          if (!strobe_q) begin
            ack   <= 1'b0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_reg_bridge.sv
// Directed plus randomized bench for control_reg_bridge with a behavioural
// model of the register map, error counter and handshake timing.
module tb_control_reg_bridge;

  localparam int NCTRL   = 8;
  localparam int NSTAT   = 8;
  localparam int TIMEOUT = 255;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;

  logic                byte_clk = 1'b0;
  logic                reset;
  logic                strobe;
  logic [15:0]         address;
  logic                requestIsWrite;
  logic [31:0]         wdata;
  logic                ack;
  logic [31:0]         rdata;
  logic [32*NCTRL-1:0] ctrlOut;
  logic [32*NSTAT-1:0] statusIn;
  logic                extStrobe;
  logic                extWrite;
  logic [15:0]         extAddress;
  logic [31:0]         extWdata;
  logic                extAck;
  logic [31:0]         extRdata;
  logic [15:0]         errCount;

  control_reg_bridge #(
    .NCTRL(NCTRL), .NSTAT(NSTAT), .EXT_BASE(16'h0100), .TIMEOUT(TIMEOUT)
  ) dut (
    .byte_clk(byte_clk), .reset(reset), .strobe(strobe), .address(address),
    .requestIsWrite(requestIsWrite), .wdata(wdata), .ack(ack), .rdata(rdata),
    .ctrlOut(ctrlOut), .statusIn(statusIn), .extStrobe(extStrobe),
    .extWrite(extWrite), .extAddress(extAddress), .extWdata(extWdata),
    .extAck(extAck), .extRdata(extRdata), .errCount(errCount)
  );

  always #5 byte_clk = ~byte_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] m_ctrl [NCTRL];
  logic [31:0] m_stat [NSTAT];
  logic [15:0] m_err;
  logic [31:0] m_rdata;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_ctrl();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < NCTRL; i++) v[32*i +: 32] = m_ctrl[i];
    return v;
  endfunction

  task automatic drive_status();
    for (int i = 0; i < NSTAT; i++) statusIn[32*i +: 32] = m_stat[i];
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCTRL; i++) m_ctrl[i] = '0;
    m_err   = '0;
    m_rdata = '0;
  endtask

  task automatic bump_err();
    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
  endtask

  // One full 4-phase transaction. dly = cycle on which extAck is presented
  // (1 = sampled on the first wait edge); 0 = never.
  task automatic run_xact(input logic [15:0] a, input logic w, input logic [31:0] d,
                          input int dly, input logic [31:0] xrd);
    int ai;
    int k;
    int exp_k;
    bit is_ext;
    ai = int'(a);
    is_ext = 1'b0;
    @(negedge byte_clk);
    address = a; requestIsWrite = w; wdata = d; strobe = 1'b1;
    if (ai < NCTRL) begin
      if (w) m_ctrl[ai] = d;
      m_rdata = m_ctrl[ai];
    end else if (ai < NCTRL + NSTAT) begin
      m_rdata = m_stat[ai - NCTRL];
    end else if (a >= 16'h0100) begin
      is_ext = 1'b1;
    end else begin
      m_rdata = DEAD;
      bump_err();
    end
    @(posedge byte_clk); @(posedge byte_clk); @(negedge byte_clk);
    chk("ack_low_before_n2", ack, 1'b0);
    @(posedge byte_clk); @(negedge byte_clk);
    if (!is_ext) begin
      chk("ack_at_n2", ack, 1'b1);
    end else begin
      chk("ext_strobe_at_n2", extStrobe, 1'b1);
      chk("ext_address", extAddress, a);
      chk("ext_write", extWrite, w);
      if (w) chk("ext_wdata", extWdata, d);
      chk("ack_low_in_ext_wait", ack, 1'b0);
      extRdata = xrd;
      exp_k = (dly >= 1 && dly <= TIMEOUT + 1) ? dly : TIMEOUT + 1;
      if (dly >= 1 && dly <= TIMEOUT + 1) m_rdata = w ? d : xrd;
      else begin
        m_rdata = DEAD;
        bump_err();
      end
      k = 0;
      for (int c = 1; c <= TIMEOUT + 20; c++) begin
        if (c == dly) extAck = 1'b1;
        @(posedge byte_clk); @(negedge byte_clk);
        extAck = 1'b0;
        k = c;
        if (!extStrobe) break;
      end
      chk("ext_strobe_high_cycles", 256'(k), 256'(exp_k));
      chk("ack_after_ext", ack, 1'b1);
    end
    chk("rdata", rdata, m_rdata);
    chk("ctrl_out", ctrlOut, exp_ctrl());
    chk("err_count", errCount, m_err);
    strobe = 1'b0;
    @(posedge byte_clk); @(negedge byte_clk);
    chk("ack_held_one_edge", ack, 1'b1);
    @(posedge byte_clk); @(negedge byte_clk);
    chk("ack_fall", ack, 1'b0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [31:0] rd;
    int sel;

    reset = 1'b1; strobe = 1'b0; address = '0; requestIsWrite = 1'b0;
    wdata = '0; extAck = 1'b0; extRdata = '0;
    for (int i = 0; i < NSTAT; i++) m_stat[i] = $urandom;
    m_stat[0] = 32'h12345678;
    drive_status();
    model_reset();
    #12;
    chk("rst_ack", ack, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ctrl", ctrlOut, 256'h0);
    chk("rst_ext", {extStrobe, extWrite, extAddress, extWdata}, 50'h0);
    chk("rst_err", errCount, 16'h0);
    @(negedge byte_clk); reset = 1'b0;

    // Directed cases
    run_xact(16'd2, 1'b1, 32'hCAFE0001, 0, 32'h0);
    chk("ctrl2_slice", ctrlOut[95:64], 32'hCAFE0001);
    run_xact(16'd2, 1'b0, 32'h0, 0, 32'h0);
    run_xact(16'(NCTRL), 1'b0, 32'h0, 0, 32'h0);
    run_xact(16'(NCTRL), 1'b1, 32'h0, 0, 32'h0);
    chk("stat_write_ignored", rdata, 32'h12345678);
    run_xact(16'h0050, 1'b0, 32'h0, 0, 32'h0);
    chk("unmapped_err_one", errCount, 16'd1);
    run_xact(16'h0200, 1'b0, 32'h0, 5, 32'hA5A5A5A5);
    run_xact(16'h0400, 1'b1, 32'h600DF00D, 0, 32'h0);
    run_xact(16'h0401, 1'b0, 32'h0, TIMEOUT + 1, 32'h5A5A0F0F);

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NSTAT; i++) m_stat[i] = $urandom;
      drive_status();
      sel = int'($urandom_range(0, 4));
      rd  = $urandom;
      case (sel)
        0: run_xact(16'($urandom_range(0, NCTRL - 1)), 1'b1, rd, 0, 32'h0);
        1: run_xact(16'($urandom_range(0, NCTRL - 1)), 1'b0, rd, 0, 32'h0);
        2: run_xact(16'($urandom_range(NCTRL, NCTRL + NSTAT - 1)), 1'($urandom_range(0, 1)), rd, 0, 32'h0);
        3: run_xact(16'($urandom_range(NCTRL + NSTAT, 16'h00FF)), 1'($urandom_range(0, 1)), rd, 0, 32'h0);
        default: begin
          ra = 16'($urandom_range(16'h0100, 16'hFFFF));
          run_xact(ra, 1'($urandom_range(0, 1)), rd, int'($urandom_range(1, 8)), $urandom);
        end
      endcase
    end

    // Abort during external wait
    @(negedge byte_clk);
    address = 16'h0300; requestIsWrite = 1'b0; wdata = 32'h0; strobe = 1'b1;
    repeat (3) @(posedge byte_clk);
    @(negedge byte_clk);
    chk("abort_ext_started", extStrobe, 1'b1);
    strobe = 1'b0;
    @(posedge byte_clk); @(posedge byte_clk); @(negedge byte_clk);
    chk("abort_ext_strobe", extStrobe, 1'b0);
    chk("abort_no_ack", ack, 1'b0);
    chk("abort_err_same", errCount, m_err);
    chk("abort_rdata_held", rdata, m_rdata);
    repeat (3) @(posedge byte_clk);
    @(negedge byte_clk);
    chk("abort_ack_stays_low", ack, 1'b0);

    // Asynchronous reset while holding ack
    address = 16'd5; requestIsWrite = 1'b1; wdata = 32'h0BAD_CAFE; strobe = 1'b1;
    repeat (3) @(posedge byte_clk);
    @(negedge byte_clk);
    m_ctrl[5] = 32'h0BAD_CAFE;
    chk("pre_reset_ack", ack, 1'b1);
    chk("pre_reset_ctrl", ctrlOut, exp_ctrl());
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_ack", ack, 1'b0);
    chk("async_rst_ctrl", ctrlOut, exp_ctrl());
    chk("async_rst_rdata", rdata, m_rdata);
    chk("async_rst_err", errCount, m_err);
    strobe = 1'b0;
    @(negedge byte_clk); reset = 1'b0;

    // Bridge still serves requests after reset
    run_xact(16'd7, 1'b1, 32'h7777_0007, 0, 32'h0);
    run_xact(16'd7, 1'b0, 32'h0, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
